aes_mem_sequencer: RTL and testbench

// - Owns port 2 (s2) of the 4x128-bit dual-port on-chip mailbox RAM. The HPS uses port 1.
// - Polls the control word. When GO is set, reads the key and input block and runs the AES core once.
// - Writes the result back, then posts DONE/TIMEOUT status and the op count to the control word.
// - Sits between the on-chip RAM and the AES core in soc_system; one clock domain (clk).

---
 rtl/aes_seq_pkg.sv | 52 +++++
 rtl/aes_mem_sequencer.sv | 158 +++++++++++++++
 tb/tb_aes_mem_sequencer.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_seq_pkg
// Description : Shared types and constants for the AES mailbox sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_POLL_RD  = 4'd1,
    S_POLL_CHK = 4'd2,
    S_KEY_RD   = 4'd3,
    S_KEY_CAP  = 4'd4,
    S_DAT_RD   = 4'd5,
    S_DAT_CAP  = 4'd6,
    S_START    = 4'd7,
    S_WAIT     = 4'd8,
    S_RES_WR   = 4'd9,
    S_STAT_WR  = 4'd10
  } state_t;

  // Mailbox word addresses
  localparam logic [1:0] C_ADDR_CTRL = 2'd0;
  localparam logic [1:0] C_ADDR_KEY  = 2'd1;
  localparam logic [1:0] C_ADDR_DATA = 2'd2;
  localparam logic [1:0] C_ADDR_RES  = 2'd3;

  // Control/status word bit positions
  localparam int C_BIT_GO   = 0;
  localparam int C_BIT_DEC  = 1;
  localparam int C_BIT_DONE = 8;
  localparam int C_BIT_TMO  = 9;
  localparam int C_OPS_LSB  = 32;

  localparam logic [15:0] C_STAT_BE = 16'h00FF;
  localparam logic [15:0] C_FULL_BE = 16'hFFFF;

  // Low 64 bits of the status word; GO is cleared by leaving bit 0 at zero.
  function automatic logic [127:0] status_word(input logic dec, input logic tmo,
                                               input logic [31:0] ops);
    logic [127:0] w;
    w                  = '0;
    w[C_BIT_DEC]       = dec;
    w[C_BIT_DONE]      = ~tmo;
    w[C_BIT_TMO]       = tmo;
    w[C_OPS_LSB +: 32] = ops;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : aes_mem_sequencer
// Description : Polls the mailbox RAM control word, feeds key/block to the AES
//               core, writes the result and posts status plus an op count.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_mem_sequencer
  import aes_seq_pkg::*;
#(
  parameter int POLL_INTERVAL  = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         reset,
  output logic [1:0]   mem_address,
  output logic         mem_chipselect,
  output logic         mem_write,
  output logic [15:0]  mem_byteenable,
  output logic [127:0] mem_writedata,
  input  logic [127:0] mem_readdata,
  output logic [127:0] aes_key,
  output logic [127:0] aes_data_in,
  output logic         aes_decrypt,
  output logic         aes_start,
  input  logic         aes_done,
  input  logic [127:0] aes_data_out,
  output logic         busy,
  output logic         irq
);

  localparam int C_CNT_MAX = (POLL_INTERVAL > TIMEOUT_CYCLES) ? POLL_INTERVAL : TIMEOUT_CYCLES;
  localparam int C_CNT_W   = $clog2(C_CNT_MAX + 1);
  localparam logic [C_CNT_W-1:0] C_POLL_LAST = C_CNT_W'(POLL_INTERVAL - 1);
  localparam logic [C_CNT_W-1:0] C_TMO_LAST  = C_CNT_W'(TIMEOUT_CYCLES - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [C_CNT_W-1:0]   r_cnt;
  logic [127:0]         r_key;
  logic [127:0]         r_data;
  logic [127:0]         r_result;
  logic                 r_decrypt;
  logic                 r_timeout;
  logic [31:0]          r_ops;

  assign aes_key     = r_key;
  assign aes_data_in = r_data;
  assign aes_decrypt = r_decrypt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // One counter serves both the idle poll spacing and the core timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_key     <= '0;
      r_data    <= '0;
      r_result  <= '0;
      r_decrypt <= 1'b0;
      r_timeout <= 1'b0;
      r_ops     <= '0;
    end else begin
      r_cnt <= '0;
      case (r_state)
        S_IDLE:     if (r_cnt != C_POLL_LAST) r_cnt <= r_cnt + 1'b1;
        S_POLL_CHK: if (mem_readdata[C_BIT_GO]) r_decrypt <= mem_readdata[C_BIT_DEC];
        S_KEY_CAP:  r_key  <= mem_readdata;
        S_DAT_CAP:  r_data <= mem_readdata;
        S_START:    r_timeout <= 1'b0;
        S_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (aes_done)                 r_result  <= aes_data_out;
          else if (r_cnt == C_TMO_LAST) r_timeout <= 1'b1;
        end
        S_STAT_WR:  r_ops <= r_ops + 1'b1;
        default:    ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    mem_address    = C_ADDR_CTRL;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    aes_start      = 1'b0;
    irq            = 1'b0;
    busy           = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (r_cnt == C_POLL_LAST) w_state_nxt = S_POLL_RD;
      end
      S_POLL_RD: begin
        busy           = 1'b0;
        mem_chipselect = 1'b1;
        mem_byteenable = C_FULL_BE;
        w_state_nxt    = S_POLL_CHK;
      end
      S_POLL_CHK: begin
        busy        = mem_readdata[C_BIT_GO];
        w_state_nxt = mem_readdata[C_BIT_GO] ? S_KEY_RD : S_IDLE;
      end
      S_KEY_RD: begin
        mem_address    = C_ADDR_KEY;
        mem_chipselect = 1'b1;
        mem_byteenable = C_FULL_BE;
        w_state_nxt    = S_KEY_CAP;
      end
      S_KEY_CAP: w_state_nxt = S_DAT_RD;
      S_DAT_RD: begin
        mem_address    = C_ADDR_DATA;
        mem_chipselect = 1'b1;
        mem_byteenable = C_FULL_BE;
        w_state_nxt    = S_DAT_CAP;
      end
      S_DAT_CAP: w_state_nxt = S_START;
      S_START: begin
        aes_start   = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // A completion in the final timeout cycle still counts as success.
        if (aes_done)                 w_state_nxt = S_RES_WR;
        else if (r_cnt == C_TMO_LAST) w_state_nxt = S_STAT_WR;
      end
      S_RES_WR: begin
        mem_address    = C_ADDR_RES;
        mem_chipselect = 1'b1;
        mem_write      = 1'b1;
        mem_byteenable = C_FULL_BE;
        mem_writedata  = r_result;
        w_state_nxt    = S_STAT_WR;
      end
      S_STAT_WR: begin
        mem_address    = C_ADDR_CTRL;
        mem_chipselect = 1'b1;
        mem_write      = 1'b1;
        mem_byteenable = C_STAT_BE;
        mem_writedata  = status_word(r_decrypt, r_timeout, r_ops + 1'b1);
        irq            = 1'b1;
        w_state_nxt    = S_IDLE;
      end
      default: begin
        busy        = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_mem_sequencer
// Description : Self-checking bench with mailbox RAM, HPS driver and core model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_mem_sequencer;

  localparam int P = 7;
  localparam int T = 50;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   mem_address;
  logic         mem_chipselect, mem_write;
  logic [15:0]  mem_byteenable;
  logic [127:0] mem_writedata, mem_readdata;
  logic [127:0] aes_key, aes_data_in, aes_data_out;
  logic         aes_decrypt, aes_start, aes_done, busy, irq;

  int checks = 0;
  int errors = 0;

  aes_mem_sequencer #(.POLL_INTERVAL(P), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .aes_key(aes_key), .aes_data_in(aes_data_in), .aes_decrypt(aes_decrypt),
    .aes_start(aes_start), .aes_done(aes_done), .aes_data_out(aes_data_out),
    .busy(busy), .irq(irq)
  );

  always #5 clk = ~clk;

  // Mailbox RAM: HPS on port 1, DUT on port 2, registered read data.
  logic [127:0] mem [4];
  logic         hps_wr = 1'b0;
  logic [1:0]   hps_addr = 2'd0;
  logic [127:0] hps_data = '0;
  always @(posedge clk) begin
    if (hps_wr) mem[hps_addr] <= hps_data;
    if (mem_chipselect && mem_write)
      for (int b = 0; b < 16; b++)
        if (mem_byteenable[b]) mem[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
    if (mem_chipselect && !mem_write) mem_readdata <= mem[mem_address];
  end

  // Stand-in core: FIPS-197 vector, otherwise an arbitrary mix of key and block.
  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] d,
                                           input logic dec);
    if (!dec && k == FIPS_KEY && d == FIPS_PT) return FIPS_CT;
    return {k[63:0], k[127:64]} ^ d ^ {128{dec}};
  endfunction

  function automatic logic [127:0] exp_w0(input logic [63:0] upper, input logic [31:0] ops,
                                          input logic dec, input logic tmo);
    return {upper, ops, 22'b0, tmo, ~tmo, 6'b0, dec, 1'b0};
  endfunction

  logic         core_done = 1'b0, stray_done = 1'b0;
  logic [127:0] core_out = '0;
  bit           core_en = 1'b1;
  int           core_lat = 0;
  assign aes_done     = core_done | stray_done;
  assign aes_data_out = core_out;

  initial begin : core_model
    logic [127:0] k, d;
    logic         dec;
    forever begin
      @(posedge clk); #1;
      if (aes_start && core_en && !reset) begin
        k = aes_key; d = aes_data_in; dec = aes_decrypt;
        repeat (core_lat) @(posedge clk);
        @(posedge clk); #1;
        core_done = 1'b1;
        core_out  = core_fn(k, d, dec);
        @(posedge clk); #1;
        core_done = 1'b0;
        core_out  = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
    end
  end

  // Passive monitor
  int   cyc = 0, irq_cnt = 0, busy_cnt = 0, start_cyc = 0, irq_cyc = 0;
  int   wr_cnt [4] = '{default: 0};
  int   rd0_q [$];
  logic dec_at_start = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (irq) begin irq_cnt++; irq_cyc = cyc; end
    if (aes_start) begin start_cyc = cyc; dec_at_start = aes_decrypt; end
    if (busy) busy_cnt++;
    if (mem_chipselect && mem_write) wr_cnt[mem_address]++;
    if (mem_chipselect && !mem_write && mem_address == 2'd0) rd0_q.push_back(cyc);
  end

  logic [31:0] model_ops = 0;

  task automatic hps_write(input logic [1:0] a, input logic [127:0] d);
    @(negedge clk);
    hps_wr = 1'b1; hps_addr = a; hps_data = d;
    @(negedge clk);
    hps_wr = 1'b0;
  endtask

  task automatic wait_irq(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (irq) begin ok = 1'b1; break; end
    end
    if (ok) begin @(posedge clk); #1; end
  endtask

  task automatic run_op(input logic [127:0] k, input logic [127:0] d, input logic dec,
                        input int lat, input bit en, output logic [63:0] upper, output bit ok);
    upper = {$urandom(), $urandom()};
    core_lat = lat; core_en = en;
    hps_write(2'd1, k);
    hps_write(2'd2, d);
    hps_write(2'd0, {upper, $urandom(), 30'b0, dec, 1'b1});
    wait_irq(4*(P+T)+40, ok);
  endtask

  task automatic test_reset;
    checks++;
    if ({mem_address, mem_chipselect, mem_write, mem_byteenable, mem_writedata} !== '0) begin
      errors++; $display("FAIL reset_mem_bus: got %h expected 0",
                         {mem_address, mem_chipselect, mem_write, mem_byteenable, mem_writedata});
    end
    checks++;
    if ({aes_key, aes_data_in, aes_decrypt} !== '0) begin
      errors++; $display("FAIL reset_aes_regs: got %h expected 0", {aes_key, aes_data_in, aes_decrypt});
    end
    checks++;
    if ({aes_start, busy, irq} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 000", {aes_start, busy, irq});
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_poll_cadence;
    int n0, b0, w0, n;
    n0 = rd0_q.size(); b0 = busy_cnt; w0 = wr_cnt[0] + wr_cnt[1] + wr_cnt[2] + wr_cnt[3];
    repeat (100) @(negedge clk);
    n = rd0_q.size();
    checks++;
    if (n - n0 < 100 / (P + 2) - 1) begin
      errors++; $display("FAIL poll_count: got %0d strobes expected >= %0d", n - n0, 100/(P+2)-1);
    end
    for (int i = n0 + 1; i < n; i++) begin
      checks++;
      if (rd0_q[i] - rd0_q[i-1] != P + 2) begin
        errors++; $display("FAIL poll_gap: got %0d expected %0d", rd0_q[i] - rd0_q[i-1], P + 2);
      end
    end
    checks++;
    if (wr_cnt[0] + wr_cnt[1] + wr_cnt[2] + wr_cnt[3] != w0) begin
      errors++; $display("FAIL poll_writes: got %0d expected 0", wr_cnt[0]+wr_cnt[1]+wr_cnt[2]+wr_cnt[3]-w0);
    end
    checks++;
    if (busy_cnt != b0) begin
      errors++; $display("FAIL poll_busy: got %0d busy cycles expected 0", busy_cnt - b0);
    end
  endtask

  task automatic test_encrypt_fips;
    logic [63:0] up; bit ok; int i0;
    i0 = irq_cnt;
    run_op(FIPS_KEY, FIPS_PT, 1'b0, 3, 1'b1, up, ok);
    model_ops++;
    checks++;
    if (!ok) begin errors++; $display("FAIL fips_irq: got timeout expected irq"); end
    checks++;
    if (mem[3] !== FIPS_CT) begin
      errors++; $display("FAIL fips_w3: got %h expected %h", mem[3], FIPS_CT);
    end
    checks++;
    if (mem[0] !== exp_w0(up, model_ops, 1'b0, 1'b0)) begin
      errors++; $display("FAIL fips_w0: got %h expected %h", mem[0], exp_w0(up, model_ops, 1'b0, 1'b0));
    end
    repeat (3) @(negedge clk);
    checks++;
    if (irq_cnt - i0 != 1) begin
      errors++; $display("FAIL fips_irq_count: got %0d expected 1", irq_cnt - i0);
    end
  endtask

  task automatic test_decrypt;
    logic [127:0] k, d; logic [63:0] up; bit ok;
    k = {$urandom(), $urandom(), $urandom(), $urandom()};
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    run_op(k, d, 1'b1, 5, 1'b1, up, ok);
    model_ops++;
    checks++;
    if (!ok) begin errors++; $display("FAIL dec_irq: got timeout expected irq"); end
    checks++;
    if (dec_at_start !== 1'b1) begin
      errors++; $display("FAIL dec_flag: got %b expected 1", dec_at_start);
    end
    checks++;
    if (mem[3] !== core_fn(k, d, 1'b1)) begin
      errors++; $display("FAIL dec_w3: got %h expected %h", mem[3], core_fn(k, d, 1'b1));
    end
    checks++;
    if (mem[0] !== exp_w0(up, model_ops, 1'b1, 1'b0)) begin
      errors++; $display("FAIL dec_w0: got %h expected %h", mem[0], exp_w0(up, model_ops, 1'b1, 1'b0));
    end
  endtask

  task automatic test_random_ops;
    logic [127:0] k, d; logic [63:0] up; logic dec; int lat; bit ok;
    for (int n = 0; n < 6; n++) begin
      k   = {$urandom(), $urandom(), $urandom(), $urandom()};
      d   = {$urandom(), $urandom(), $urandom(), $urandom()};
      dec = 1'($urandom_range(0, 1));
      lat = $urandom_range(0, T - 2);
      run_op(k, d, dec, lat, 1'b1, up, ok);
      model_ops++;
      checks++;
      if (!ok) begin errors++; $display("FAIL rnd_irq[%0d]: got timeout expected irq", n); end
      checks++;
      if (irq_cyc - start_cyc != lat + 3) begin
        errors++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", n, irq_cyc - start_cyc, lat + 3);
      end
      checks++;
      if (mem[3] !== core_fn(k, d, dec)) begin
        errors++; $display("FAIL rnd_w3[%0d]: got %h expected %h", n, mem[3], core_fn(k, d, dec));
      end
      checks++;
      if (mem[0] !== exp_w0(up, model_ops, dec, 1'b0)) begin
        errors++; $display("FAIL rnd_w0[%0d]: got %h expected %h", n, mem[0], exp_w0(up, model_ops, dec, 1'b0));
      end
    end
  endtask

  task automatic test_timeout;
    logic [127:0] w3_before; logic [63:0] up; logic dec; bit ok; int w3c;
    w3_before = mem[3]; w3c = wr_cnt[3];
    dec = 1'($urandom_range(0, 1));
    run_op({4{32'h5a5a_0f0f}}, {4{32'h1234_abcd}}, dec, 0, 1'b0, up, ok);
    model_ops++;
    core_en = 1'b1;
    checks++;
    if (!ok) begin errors++; $display("FAIL tmo_irq: got no irq expected irq"); end
    checks++;
    if (irq_cyc - start_cyc != T + 1) begin
      errors++; $display("FAIL tmo_cycles: got %0d expected %0d", irq_cyc - start_cyc, T + 1);
    end
    checks++;
    if (mem[3] !== w3_before || wr_cnt[3] != w3c) begin
      errors++; $display("FAIL tmo_w3: got %h (%0d writes) expected %h unchanged", mem[3], wr_cnt[3]-w3c, w3_before);
    end
    checks++;
    if (mem[0] !== exp_w0(up, model_ops, dec, 1'b1)) begin
      errors++; $display("FAIL tmo_w0: got %h expected %h", mem[0], exp_w0(up, model_ops, dec, 1'b1));
    end
  endtask

  task automatic test_done_timeout_tie;
    logic [127:0] k, d; logic [63:0] up; bit ok;
    k = {$urandom(), $urandom(), $urandom(), $urandom()};
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    run_op(k, d, 1'b0, T - 1, 1'b1, up, ok);
    model_ops++;
    checks++;
    if (!ok || irq_cyc - start_cyc != T + 2) begin
      errors++; $display("FAIL tie_cycles: got %0d (irq %0d) expected %0d", irq_cyc - start_cyc, ok, T + 2);
    end
    checks++;
    if (mem[3] !== core_fn(k, d, 1'b0)) begin
      errors++; $display("FAIL tie_w3: got %h expected %h", mem[3], core_fn(k, d, 1'b0));
    end
    checks++;
    if (mem[0] !== exp_w0(up, model_ops, 1'b0, 1'b0)) begin
      errors++; $display("FAIL tie_w0: got %h expected %h", mem[0], exp_w0(up, model_ops, 1'b0, 1'b0));
    end
  endtask

  task automatic test_reset_mid_wait;
    logic [127:0] k, d; logic [63:0] up; bit ok, seen; int wc;
    k  = {$urandom(), $urandom(), $urandom(), $urandom()};
    d  = {$urandom(), $urandom(), $urandom(), $urandom()};
    up = {$urandom(), $urandom()};
    core_en = 1'b0;
    hps_write(2'd1, k);
    hps_write(2'd2, d);
    hps_write(2'd0, {up, 32'h0, 30'b0, 1'b1, 1'b1});
    seen = 1'b0;
    for (int i = 0; i < 4*(P+2)+20 && !seen; i++) begin
      @(negedge clk);
      if (aes_start) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rst_start: got no aes_start expected start"); end
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({mem_address, mem_chipselect, mem_write, mem_byteenable, mem_writedata, aes_key,
         aes_data_in, aes_decrypt, aes_start, busy, irq} !== '0) begin
      errors++; $display("FAIL rst_outputs: got key=%h cs=%b busy=%b dec=%b expected all 0",
                         aes_key, mem_chipselect, busy, aes_decrypt);
    end
    wc = wr_cnt[0] + wr_cnt[3];
    repeat (4) @(negedge clk);
    checks++;
    if (wr_cnt[0] + wr_cnt[3] != wc || mem[0][0] !== 1'b1) begin
      errors++; $display("FAIL rst_no_write: got %0d writes, GO=%b expected 0 writes, GO=1",
                         wr_cnt[0] + wr_cnt[3] - wc, mem[0][0]);
    end
    model_ops = 0;
    core_en = 1'b1; core_lat = $urandom_range(0, 10);
    reset = 1'b0;
    wait_irq(4*(P+T)+40, ok);
    model_ops++;
    checks++;
    if (!ok || mem[3] !== core_fn(k, d, 1'b1)) begin
      errors++; $display("FAIL rst_rerun_w3: got %h (irq %0d) expected %h", mem[3], ok, core_fn(k, d, 1'b1));
    end
    checks++;
    if (mem[0] !== exp_w0(up, model_ops, 1'b1, 1'b0)) begin
      errors++; $display("FAIL rst_rerun_w0: got %h expected %h", mem[0], exp_w0(up, model_ops, 1'b1, 1'b0));
    end
  endtask

  task automatic test_back_to_back;
    logic [127:0] k, d; logic [63:0] up, up2; bit ok; int i0, w0c, w3c;
    k  = {$urandom(), $urandom(), $urandom(), $urandom()};
    d  = {$urandom(), $urandom(), $urandom(), $urandom()};
    i0 = irq_cnt; w0c = wr_cnt[0]; w3c = wr_cnt[3];
    run_op(k, d, 1'b0, 2, 1'b1, up, ok);
    model_ops++;
    checks++;
    if (!ok || mem[3] !== core_fn(k, d, 1'b0)) begin
      errors++; $display("FAIL b2b_first: got %h (irq %0d) expected %h", mem[3], ok, core_fn(k, d, 1'b0));
    end
    up2 = {$urandom(), $urandom()};
    core_lat = 4;
    @(negedge clk);
    stray_done = 1'b1; core_out = ~core_fn(k, d, 1'b1);
    hps_wr = 1'b1; hps_addr = 2'd0; hps_data = {up2, 32'h0, 30'b0, 1'b1, 1'b1};
    @(negedge clk);
    stray_done = 1'b0; hps_wr = 1'b0;
    wait_irq(4*(P+T)+40, ok);
    model_ops++;
    checks++;
    if (!ok || mem[3] !== core_fn(k, d, 1'b1)) begin
      errors++; $display("FAIL b2b_second_w3: got %h (irq %0d) expected %h", mem[3], ok, core_fn(k, d, 1'b1));
    end
    checks++;
    if (mem[0] !== exp_w0(up2, model_ops, 1'b1, 1'b0)) begin
      errors++; $display("FAIL b2b_w0: got %h expected %h", mem[0], exp_w0(up2, model_ops, 1'b1, 1'b0));
    end
    repeat (3) @(negedge clk);
    checks++;
    if (irq_cnt - i0 != 2 || wr_cnt[0] - w0c != 2 || wr_cnt[3] - w3c != 2) begin
      errors++; $display("FAIL b2b_counts: got irq=%0d w0wr=%0d w3wr=%0d expected 2/2/2",
                         irq_cnt - i0, wr_cnt[0] - w0c, wr_cnt[3] - w3c);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 4; i++) hps_write(2'(i), '0);
    test_reset;
    test_poll_cadence;
    test_encrypt_fips;
    test_decrypt;
    test_random_ops;
    test_timeout;
    test_done_timeout_tie;
    test_reset_mid_wait;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
